// File: rtl/imem_fetch_if.sv
// Program-load port of imem_fetch: valid/ready handshake carrying one word address and data.
interface imem_fetch_if;
  logic        prog_valid;
  logic        prog_ready;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;

  modport master (
    output prog_valid,
    output prog_addr,
    output prog_data,
    input  prog_ready
  );

  modport slave (
    input  prog_valid,
    input  prog_addr,
    input  prog_data,
    output prog_ready
  );
endinterface

// File: rtl/imem_fetch.sv
// imem_fetch: 16 x 16-bit instruction memory with LOAD/RUN fetch control for the 4-bit CPU.
// Defining IMEM_HALT_EN adds a HALT state entered when 16'hFFFF is fetched in RUN.
module imem_fetch (
  input  logic        clk,
  input  logic        rst_n,
  imem_fetch_if.slave prog,
  input  logic        run,
  input  logic [3:0]  PC_CURR,
  output logic [15:0] INS,
  output logic        set_pc,
  output logic [4:0]  load_cnt,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

`ifdef IMEM_HALT_EN
  localparam logic [15:0] HALT_WORD = 16'hFFFF;
`endif
  localparam logic [4:0] CNT_MAX = 5'd16;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] mem_r [16];
  logic [4:0]  load_cnt_r;
  logic [15:0] ins_s;
  logic        wr_en_s;
  logic        enter_load_s;

  // Memory is only writable while loading; RUN and HALT ignore prog_valid.
  assign wr_en_s      = (state_r == ST_LOAD) && prog.prog_valid;
  assign enter_load_s = (state_r != ST_LOAD) && (state_nxt_s == ST_LOAD);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a low run always wins over the halt word.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (run) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_nxt_s = ST_LOAD;
`ifdef IMEM_HALT_EN
        end else if (ins_s == HALT_WORD) begin
          state_nxt_s = ST_HALT;
`endif
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
`ifdef IMEM_HALT_EN
        if (run) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_LOAD;
        end
`else
        state_nxt_s = ST_LOAD;
`endif
      end
      default: begin
        state_nxt_s = ST_LOAD;
      end
    endcase
  end

  // Program storage; reset clears every word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (wr_en_s) begin
      mem_r[prog.prog_addr] <= prog.prog_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Accepted-word counter: saturates at 16, cleared whenever LOAD is re-entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt_r <= 5'd0;
    end else if (enter_load_s) begin
      load_cnt_r <= 5'd0;
    end else if (wr_en_s && (load_cnt_r != CNT_MAX)) begin
      load_cnt_r <= load_cnt_r + 5'd1;
    end else begin
      load_cnt_r <= load_cnt_r;
    end
  end

  // Asynchronous fetch: the PC consumes INS in the same cycle it presents PC_CURR.
  always_comb begin
    ins_s = 16'h0000;
    if (state_r == ST_RUN) begin
      ins_s = mem_r[PC_CURR];
    end else begin
      ins_s = 16'h0000;
    end
  end

  assign INS             = ins_s;
  assign prog.prog_ready = (state_r == ST_LOAD);
  assign set_pc          = (state_r != ST_RUN);
  assign load_cnt        = load_cnt_r;
`ifdef IMEM_HALT_EN
  assign halted          = (state_r == ST_HALT);
`else
  assign halted          = 1'b0;
`endif

endmodule
